// File: rtl/decode_bundle_feeder_pkg.sv
// Shared sizing, packet field offsets and the compacted bundle record for the
// decode-to-instruction-buffer feeder.
package decode_bundle_feeder_pkg;

  localparam int PKT_W = 96;
  localparam int LANES = 8;
  localparam int DEPTH = 2;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int N_W   = $clog2(LANES + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Decoded packet field layout; the buffer counts branches from CTI_BIT.
  localparam int CTI_BIT   = 0;
  localparam int OPC_LSB   = 1;
  localparam int OPC_W     = 15;
  localparam int PC_LSB    = 64;
  localparam int PC_W      = 32;

  typedef struct packed {
    logic [N_W-1:0]                n;
    logic [LANES-1:0][PKT_W-1:0]   packets;
  } bundle_t;

  // Contiguous low-slot mask for n valid lanes: (1<<n)-1, n=LANES gives all ones.
  function automatic logic [LANES-1:0] lane_mask(input logic [N_W-1:0] n);
    logic [LANES:0] full;
    full = ((LANES+1)'(1) << n) - (LANES+1)'(1);
    return full[LANES-1:0];
  endfunction

endpackage

// File: rtl/decode_bundle_feeder_bundle_compactor.sv
// Packs the set lanes of a sparse bundle into contiguous low slots, ascending
// lane order. Purely combinational.
module bundle_compactor
  import decode_bundle_feeder_pkg::*;
(
  input  logic [LANES-1:0]            vec,
  input  logic [LANES-1:0][PKT_W-1:0] pkt,
  output bundle_t                     bundle
);

  logic [N_W-1:0]              pos [LANES];
  logic [N_W-1:0]              run;
  logic [LANES-1:0][PKT_W-1:0] slot;

  // pos[i] is the number of set lanes below lane i, i.e. its destination slot.
  always_comb begin
    run = '0;
    for (int i = 0; i < LANES; i++) begin
      pos[i] = run;
      run    = run + {{(N_W-1){1'b0}}, vec[i]};
    end
  end

  always_comb begin
    slot = '0;
    for (int j = 0; j < LANES; j++) begin
      for (int i = 0; i < LANES; i++) begin
        if (vec[i] && (pos[i] == N_W'(j))) begin
          slot[j] = pkt[i];
        end
      end
    end
  end

  assign bundle.n       = run;
  assign bundle.packets = slot;

endmodule

// File: rtl/decode_bundle_feeder.sv
// Compacts decoded bundles and queues them for the instruction buffer, holding
// them while the buffer stalls. Output appears one cycle after acceptance.
module decode_bundle_feeder
  import decode_bundle_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               bundleValid_i,
  input  logic [LANES-1:0]   bundleVector_i,
  input  logic [PKT_W-1:0]   bundlePacket0_i,
  input  logic [PKT_W-1:0]   bundlePacket1_i,
  input  logic [PKT_W-1:0]   bundlePacket2_i,
  input  logic [PKT_W-1:0]   bundlePacket3_i,
  input  logic [PKT_W-1:0]   bundlePacket4_i,
  input  logic [PKT_W-1:0]   bundlePacket5_i,
  input  logic [PKT_W-1:0]   bundlePacket6_i,
  input  logic [PKT_W-1:0]   bundlePacket7_i,
  output logic               bundleReady_o,
  input  logic               stallFetch_i,
  output logic               decodeReady_o,
  output logic [LANES-1:0]   decodedVector_o,
  output logic [PKT_W-1:0]   decodedPacket0_o,
  output logic [PKT_W-1:0]   decodedPacket1_o,
  output logic [PKT_W-1:0]   decodedPacket2_o,
  output logic [PKT_W-1:0]   decodedPacket3_o,
  output logic [PKT_W-1:0]   decodedPacket4_o,
  output logic [PKT_W-1:0]   decodedPacket5_o,
  output logic [PKT_W-1:0]   decodedPacket6_o,
  output logic [PKT_W-1:0]   decodedPacket7_o,
  output logic [CNT_W-1:0]   occupancy_o
);

  logic [LANES-1:0][PKT_W-1:0] in_pkt;
  logic [LANES-1:0][PKT_W-1:0] out_pkt;
  bundle_t                     compacted;
  bundle_t                     mem [DEPTH];
  bundle_t                     head_entry;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             enq;
  logic             deq;
  logic [LANES-1:0] head_mask;

  assign in_pkt = {bundlePacket7_i, bundlePacket6_i, bundlePacket5_i, bundlePacket4_i,
                   bundlePacket3_i, bundlePacket2_i, bundlePacket1_i, bundlePacket0_i};

  bundle_compactor u_compactor (
    .vec    (bundleVector_i),
    .pkt    (in_pkt),
    .bundle (compacted)
  );

  assign bundleReady_o = (count < DEPTH_C);
  assign decodeReady_o = (count != '0);
  assign occupancy_o   = count;

  // Empty bundles complete the handshake but take no queue slot.
  assign enq = bundleValid_i & bundleReady_o & ~flush_i & (compacted.n != '0);
  assign deq = decodeReady_o & ~stallFetch_i & ~flush_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush_i) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= compacted;
  end

  // Unreset storage never reaches the pins: everything is gated by a valid head.
  assign head_entry = mem[head];
  assign head_mask  = decodeReady_o ? lane_mask(head_entry.n) : '0;

  always_comb begin
    out_pkt = '0;
    for (int j = 0; j < LANES; j++) begin
      if (head_mask[j]) out_pkt[j] = head_entry.packets[j];
    end
  end

  assign decodedVector_o  = head_mask;
  assign decodedPacket0_o = out_pkt[0];
  assign decodedPacket1_o = out_pkt[1];
  assign decodedPacket2_o = out_pkt[2];
  assign decodedPacket3_o = out_pkt[3];
  assign decodedPacket4_o = out_pkt[4];
  assign decodedPacket5_o = out_pkt[5];
  assign decodedPacket6_o = out_pkt[6];
  assign decodedPacket7_o = out_pkt[7];

endmodule

// File: tb/tb_decode_bundle_feeder.sv
// Directed bench for decode_bundle_feeder: reset, compaction, stall hold,
// empty bundles, streaming with wrap, and flush.
module tb_decode_bundle_feeder;
  import decode_bundle_feeder_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             bvalid;
  logic [7:0]       bvec;
  logic [95:0]      pin  [8];
  logic [95:0]      pout [8];
  logic             bready;
  logic             stall;
  logic             dready;
  logic [7:0]       dvec;
  logic [1:0]       occ;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_bundle_feeder dut (
    .clk              (clk),
    .reset            (reset),
    .flush_i          (flush),
    .bundleValid_i    (bvalid),
    .bundleVector_i   (bvec),
    .bundlePacket0_i  (pin[0]),
    .bundlePacket1_i  (pin[1]),
    .bundlePacket2_i  (pin[2]),
    .bundlePacket3_i  (pin[3]),
    .bundlePacket4_i  (pin[4]),
    .bundlePacket5_i  (pin[5]),
    .bundlePacket6_i  (pin[6]),
    .bundlePacket7_i  (pin[7]),
    .bundleReady_o    (bready),
    .stallFetch_i     (stall),
    .decodeReady_o    (dready),
    .decodedVector_o  (dvec),
    .decodedPacket0_o (pout[0]),
    .decodedPacket1_o (pout[1]),
    .decodedPacket2_o (pout[2]),
    .decodedPacket3_o (pout[3]),
    .decodedPacket4_o (pout[4]),
    .decodedPacket5_o (pout[5]),
    .decodedPacket6_o (pout[6]),
    .decodedPacket7_o (pout[7]),
    .occupancy_o      (occ)
  );

  function automatic logic [95:0] tag(input int b, input int l);
    return {32'hC0DE_0000 | 32'(b), 32'(l), 32'(b * 16 + l) ^ 32'h5A5A_0000};
  endfunction

  task automatic chk(input string name, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int id, input logic [7:0] v);
    bvalid = 1'b1;
    bvec   = v;
    for (int i = 0; i < 8; i++) pin[i] = tag(id, i);
  endtask

  task automatic idle();
    bvalid = 1'b0;
    bvec   = 8'h00;
  endtask

  task automatic chk_empty(input string name);
    chk({name, "_rdy"}, 96'(dready), 96'd0);
    chk({name, "_vec"}, 96'(dvec), 96'd0);
    chk({name, "_occ"}, 96'(occ), 96'd0);
    for (int i = 0; i < 8; i++) chk({name, "_pkt"}, pout[i], 96'd0);
  endtask

  // Streaming table: vector, expected mask, first lane, last lane.
  logic [7:0] s_vec  [10] = '{8'h01, 8'h80, 8'hFF, 8'h3C, 8'h81, 8'h10, 8'hAA, 8'h55, 8'hF0, 8'h0E};
  logic [7:0] s_mask [10] = '{8'h01, 8'h01, 8'hFF, 8'h0F, 8'h03, 8'h01, 8'h0F, 8'h0F, 8'h0F, 8'h07};
  int         s_first[10] = '{0, 7, 0, 2, 0, 4, 1, 0, 4, 1};
  int         s_last [10] = '{0, 7, 7, 5, 7, 4, 7, 6, 7, 3};
  int         s_n    [10] = '{1, 1, 8, 4, 2, 1, 4, 4, 4, 3};

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 8; i++) pin[i] = '0;
    idle();
    tick();
    tick();
    chk_empty("reset");
    chk("reset_bready", 96'(bready), 96'd1);
    reset = 1'b1;
    tick();

    // Sparse bundle 1010_0101 -> lanes 0,2,5,7 in slots 0..3.
    present(1, 8'b1010_0101);
    chk("sparse_bready", 96'(bready), 96'd1);
    tick();
    idle();
    chk("sparse_rdy", 96'(dready), 96'd1);
    chk("sparse_vec", 96'(dvec), 96'h0F);
    chk("sparse_occ", 96'(occ), 96'd1);
    chk("sparse_s0", pout[0], tag(1, 0));
    chk("sparse_s1", pout[1], tag(1, 2));
    chk("sparse_s2", pout[2], tag(1, 5));
    chk("sparse_s3", pout[3], tag(1, 7));
    for (int i = 4; i < 8; i++) chk("sparse_hi", pout[i], 96'd0);
    tick();
    chk_empty("sparse_drain");

    // Stall: A (FF) and B (03) held; a third bundle is refused while full.
    stall = 1'b1;
    present(2, 8'hFF);
    tick();
    chk("stall_occ1", 96'(occ), 96'd1);
    present(3, 8'h03);
    tick();
    present(4, 8'hFF);
    for (int c = 0; c < 4; c++) begin
      chk("stall_occ2", 96'(occ), 96'd2);
      chk("stall_bready", 96'(bready), 96'd0);
      chk("stall_vec", 96'(dvec), 96'hFF);
      chk("stall_s0", pout[0], tag(2, 0));
      chk("stall_s7", pout[7], tag(2, 7));
      tick();
    end
    idle();
    stall = 1'b0;
    chk("unstall_A_vec", 96'(dvec), 96'hFF);
    chk("unstall_A_s3", pout[3], tag(2, 3));
    tick();
    chk("unstall_B_vec", 96'(dvec), 96'h03);
    chk("unstall_B_s0", pout[0], tag(3, 0));
    chk("unstall_B_s1", pout[1], tag(3, 1));
    chk("unstall_B_s2", pout[2], 96'd0);
    chk("unstall_B_occ", 96'(occ), 96'd1);
    tick();
    chk_empty("unstall_drain");

    // Zero-vector bundle: accepted but never queued.
    present(5, 8'h00);
    chk("zero_bready", 96'(bready), 96'd1);
    tick();
    idle();
    chk_empty("zero");

    // Back-to-back stream of 10, pointers wrap repeatedly.
    for (int k = 0; k < 10; k++) begin
      present(10 + k, s_vec[k]);
      tick();
      chk("stream_rdy", 96'(dready), 96'd1);
      chk("stream_occ", 96'(occ), 96'd1);
      chk("stream_vec", 96'(dvec), 96'(s_mask[k]));
      chk("stream_first", pout[0], tag(10 + k, s_first[k]));
      chk("stream_last", pout[s_n[k] - 1], tag(10 + k, s_last[k]));
    end
    idle();
    tick();
    chk_empty("stream_drain");

    // Flush at occupancy 2 with a bundle presented.
    stall = 1'b1;
    present(30, 8'h0F);
    tick();
    present(31, 8'hF0);
    tick();
    chk("pflush_occ", 96'(occ), 96'd2);
    present(32, 8'hFF);
    flush = 1'b1;
    stall = 1'b0;
    tick();
    flush = 1'b0;
    idle();
    chk_empty("flush_full");
    tick();
    chk_empty("flush_full_after");

    // Flush at occupancy 1 while a new bundle is handshaked.
    stall = 1'b1;
    present(33, 8'h01);
    tick();
    present(34, 8'hFF);
    chk("flush_hs_bready", 96'(bready), 96'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk_empty("flush_hs");
    stall = 1'b0;
    tick();
    chk_empty("flush_hs_after");

    // Reset mid-stream with two bundles held: outputs clear without a clock edge.
    stall = 1'b1;
    present(40, 8'hFF);
    tick();
    present(41, 8'hFF);
    tick();
    idle();
    chk("mid_occ", 96'(occ), 96'd2);
    #2;
    reset = 1'b0;
    #1;
    chk_empty("mid_reset");
    tick();
    reset = 1'b1;
    stall = 1'b0;
    chk("mid_bready", 96'(bready), 96'd1);
    present(42, 8'h40);
    tick();
    idle();
    chk("post_reset_vec", 96'(dvec), 96'h01);
    chk("post_reset_s0", pout[0], tag(42, 6));
    tick();
    chk_empty("post_reset_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
